riscv_v_rf_rd_seq: RTL

- Operand read sequencer directly downstream of the vector register file read ports.
- Accepts one vector-op read request (vs1, vs2, vd, LMUL) and drives the RF rd_addr_A/rd_addr_B for each register of the LMUL group, one register per beat.
- Captures the RF asynchronous read data into an output register and presents each beat to the execute stage over a valid/ready handshake.

---
 rtl/riscv_v_pkg.sv | 36 +++
 rtl/riscv_v_rf_rd_seq.sv | 114 +++++++++++
 2 files changed

// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: RF address/data, LMUL encoding and
// read-sequencer state.
package riscv_v_pkg;

  localparam int RISCV_V_VLEN      = 64;
  localparam int RISCV_V_MAX_GROUP = 8;

  typedef logic [4:0]              riscv_v_rf_addr_t;
  typedef logic [RISCV_V_VLEN-1:0] riscv_v_data_t;

  typedef enum logic [1:0] {
    LMUL1,
    LMUL2,
    LMUL4,
    LMUL8
  } riscv_v_lmul_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } riscv_v_rd_seq_state_t;

  // Index of the final register in a group (n_beats - 1).
  function automatic logic [2:0] lmul_last(input riscv_v_lmul_t l);
    logic [2:0] r;
    r = 3'd0;
    unique case (l)
      LMUL1: r = 3'd0;
      LMUL2: r = 3'd1;
      LMUL4: r = 3'd3;
      LMUL8: r = 3'd7;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_v_rf_rd_seq.sv
// Vector RF operand read sequencer: walks an LMUL register group one
// register per beat and registers the RF read data toward execute.
module riscv_v_rf_rd_seq
  import riscv_v_pkg::*;
#(
  parameter int MAX_LMUL_LOG2 = 3,
  parameter bit CHECK_ALIGN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  riscv_v_rf_addr_t req_vs1,
  input  riscv_v_rf_addr_t req_vs2,
  input  riscv_v_rf_addr_t req_vd,
  input  logic [1:0]       req_lmul,
  input  logic             kill,
  output riscv_v_rf_addr_t rd_addr_A,
  output riscv_v_rf_addr_t rd_addr_B,
  input  riscv_v_data_t    rf_data_A,
  input  riscv_v_data_t    rf_data_B,
  output logic             op_valid,
  input  logic             op_ready,
  output riscv_v_data_t    op_a,
  output riscv_v_data_t    op_b,
  output riscv_v_rf_addr_t op_vd,
  output logic [2:0]       op_beat,
  output logic             op_last,
  output logic             err
);

  riscv_v_rd_seq_state_t state;
  riscv_v_rf_addr_t      vs1_q;
  riscv_v_rf_addr_t      vs2_q;
  riscv_v_rf_addr_t      vd_q;
  logic [2:0]            beat;
  logic [2:0]            last_beat;
  logic [2:0]            req_mask;
  logic                  lmul_bad;
  logic                  align_bad;
  logic                  req_bad;
  logic                  advance;

  assign req_mask  = lmul_last(riscv_v_lmul_t'(req_lmul));
  assign lmul_bad  = {30'd0, req_lmul} > 32'(MAX_LMUL_LOG2);
  assign align_bad = CHECK_ALIGN &&
                     (|(req_vs1[2:0] & req_mask) ||
                      |(req_vs2[2:0] & req_mask) ||
                      |(req_vd[2:0]  & req_mask));
  assign req_bad   = lmul_bad || align_bad;

  assign req_ready = (state == IDLE);
  assign advance   = !op_valid || op_ready;
  assign rd_addr_A = vs1_q + {2'b00, beat};
  assign rd_addr_B = vs2_q + {2'b00, beat};

  // beat is left on the final index after the last capture so the
  // RF addresses keep their last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vd_q      <= '0;
      beat      <= '0;
      last_beat <= '0;
      op_valid  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_vd     <= '0;
      op_beat   <= '0;
      op_last   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (kill) begin
        state    <= IDLE;
        op_valid <= 1'b0;
        beat     <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (op_ready) op_valid <= 1'b0;
            if (req_valid) begin
              if (req_bad) begin
                err <= 1'b1;
              end else begin
                vs1_q     <= req_vs1;
                vs2_q     <= req_vs2;
                vd_q      <= req_vd;
                last_beat <= req_mask;
                beat      <= '0;
                state     <= ISSUE;
              end
            end
          end
          ISSUE: begin
            if (advance) begin
              op_a     <= rf_data_A;
              op_b     <= rf_data_B;
              op_vd    <= vd_q + {2'b00, beat};
              op_beat  <= beat;
              op_last  <= (beat == last_beat);
              op_valid <= 1'b1;
              if (beat == last_beat) state <= IDLE;
              else beat <= beat + 3'd1;
            end
          end
        endcase
      end
    end
  end

endmodule
